// File: rtl/ram_share_ctrl_if.sv
// Requester and RAM-side bundle for the shared single-port RAM controller.
// The controller uses the slave view; requesters and the RAM use the master view.
interface ram_share_ctrl_if #(
  parameter int AW = 4,
  parameter int DW = 4
);
  logic          req0;
  logic          req1;
  logic          we0;
  logic          we1;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata0;
  logic [DW-1:0] wdata1;
  logic          ack0;
  logic          ack1;
  logic [DW-1:0] rdata0;
  logic [DW-1:0] rdata1;
  logic          busy;
  logic          ram_wr;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_dout,
    output ack0, ack1, rdata0, rdata1, busy, ram_wr, ram_addr, ram_din
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_dout,
    input  ack0, ack1, rdata0, rdata1, busy, ram_wr, ram_addr, ram_din
  );
endinterface

// File: rtl/ram_share_ctrl.sv
// Round-robin arbiter/sequencer letting two requesters share one 16x4 single-port RAM.
//
// state | meaning
// IDLE  | waiting for a request; arbitrates and latches the winner
// GRANT | RAM pins driven with the latched access for one cycle
// WAIT  | read data from RAM is valid; captured into rdata[sel]
// RESP  | one-cycle ack to the selected port
module ram_share_ctrl #(
  parameter int AW = 4,
  parameter int DW = 4
) (
  input  logic              clk,
  input  logic              rst,
  ram_share_ctrl_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, GRANT, WAIT, RESP} state_t;

  state_t        state;
  state_t        state_nxt;
  logic          sel;
  logic          last;
  logic          lat_we;
  logic [AW-1:0] lat_addr;
  logic [DW-1:0] lat_din;
  logic [DW-1:0] rdata0_q;
  logic [DW-1:0] rdata1_q;
  logic          any_req;
  logic          pick;

  assign any_req = bus.req0 | bus.req1;
  // Port 1 wins when alone, or when both ask and port 1 was not served last.
  assign pick    = bus.req1 & (~bus.req0 | ~last);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    bus.ack0   = 1'b0;
    bus.ack1   = 1'b0;
    bus.busy   = 1'b1;
    bus.ram_wr = 1'b0;
    case (state)
      IDLE: begin
        bus.busy = 1'b0;
        if (any_req) state_nxt = GRANT;
      end
      GRANT: begin
        bus.ram_wr = lat_we;
        state_nxt  = lat_we ? RESP : WAIT;
      end
      WAIT: state_nxt = RESP;
      RESP: begin
        bus.ack0  = ~sel;
        bus.ack1  = sel;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel      <= 1'b0;
      last     <= 1'b1;
      lat_we   <= 1'b0;
      lat_addr <= '0;
      lat_din  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            sel      <= pick;
            lat_we   <= pick ? bus.we1    : bus.we0;
            lat_addr <= pick ? bus.addr1  : bus.addr0;
            lat_din  <= pick ? bus.wdata1 : bus.wdata0;
          end
        end
        WAIT: begin
          if (sel) rdata1_q <= bus.ram_dout;
          else     rdata0_q <= bus.ram_dout;
        end
        RESP: last <= sel;
        default: ;
      endcase
    end
  end

  // RAM address/data hold their last latched value outside GRANT.
  assign bus.ram_addr = lat_addr;
  assign bus.ram_din  = lat_din;
  assign bus.rdata0   = rdata0_q;
  assign bus.rdata1   = rdata1_q;
endmodule

// File: tb/tb_ram_share_ctrl.sv
// Self-checking bench for ram_share_ctrl with a behavioural RAM and a spec-level model.
module tb_ram_share_ctrl;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  ram_share_ctrl_if #(.AW(4), .DW(4)) bus ();

  ram_share_ctrl #(.AW(4), .DW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural 16x4 RAM: write on wr, otherwise register the addressed word.
  logic [3:0] ram_mem [16];
  always @(posedge clk) begin
    if (bus.ram_wr) ram_mem[bus.ram_addr] <= bus.ram_din;
    else            bus.ram_dout <= ram_mem[bus.ram_addr];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: memory contents, expected rdata per port, last served port.
  logic [3:0] ref_mem [16];
  logic [3:0] exp_rd0;
  logic [3:0] exp_rd1;
  bit         model_last;

  function automatic void model_reset();
    exp_rd0    = 4'h0;
    exp_rd1    = 4'h0;
    model_last = 1'b1;
  endfunction

  function automatic void model_apply(input bit p, input bit we, input logic [3:0] a, input logic [3:0] d);
    if (we) ref_mem[a] = d;
    else if (p) exp_rd1 = ref_mem[a];
    else exp_rd0 = ref_mem[a];
    model_last = p;
  endfunction

  function automatic bit model_winner(input bit r0, input bit r1);
    if (r0 && r1) return ~model_last;
    return r1;
  endfunction

  task automatic idle_inputs();
    bus.req0   = 1'b0;
    bus.req1   = 1'b0;
    bus.we0    = 1'($urandom_range(0, 1));
    bus.we1    = 1'($urandom_range(0, 1));
    bus.addr0  = 4'($urandom_range(0, 15));
    bus.addr1  = 4'($urandom_range(0, 15));
    bus.wdata0 = 4'($urandom_range(0, 15));
    bus.wdata1 = 4'($urandom_range(0, 15));
  endtask

  task automatic quiet_reset();
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  // Drives one request on port p and observes it until its ack (bounded).
  task automatic run_single(input bit p, input bit we, input logic [3:0] a, input logic [3:0] d,
                            output int lat, output int wr_cnt, output logic [3:0] wa,
                            output logic [3:0] wd, output bit other_ack);
    lat = -1; wr_cnt = 0; wa = 4'h0; wd = 4'h0; other_ack = 1'b0;
    @(negedge clk);
    idle_inputs();
    if (p) begin
      bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d;
    end else begin
      bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d;
    end
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (bus.ram_wr) begin
        wr_cnt++;
        wa = bus.ram_addr;
        wd = bus.ram_din;
      end
      if (p ? bus.ack0 : bus.ack1) other_ack = 1'b1;
      if (p ? bus.ack1 : bus.ack0) begin
        lat = c;
        break;
      end
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0;
    bus.req0  = 1'($urandom_range(0, 1));
    bus.req1  = 1'($urandom_range(0, 1));
    bus.addr0 = 4'($urandom_range(0, 15));
    bus.addr1 = 4'($urandom_range(0, 15));
    #1;
    checks++; if (bus.ack0 !== 1'b0 || bus.ack1 !== 1'b0) begin errors++; $display("FAIL reset_ack got %b%b exp 00", bus.ack0, bus.ack1); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
    checks++; if (bus.ram_wr !== 1'b0) begin errors++; $display("FAIL reset_ram_wr got %b exp 0", bus.ram_wr); end
    checks++; if (bus.ram_addr !== 4'h0) begin errors++; $display("FAIL reset_ram_addr got %h exp 0", bus.ram_addr); end
    checks++; if (bus.ram_din !== 4'h0) begin errors++; $display("FAIL reset_ram_din got %h exp 0", bus.ram_din); end
    checks++; if (bus.rdata0 !== 4'h0 || bus.rdata1 !== 4'h0) begin errors++; $display("FAIL reset_rdata got %h/%h exp 0/0", bus.rdata0, bus.rdata1); end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bus.req0  = 1'($urandom_range(0, 1));
      bus.req1  = 1'($urandom_range(0, 1));
      bus.addr0 = 4'($urandom_range(0, 15));
      checks++; if (bus.ack0 !== 1'b0 || bus.ack1 !== 1'b0 || bus.busy !== 1'b0)
        begin errors++; $display("FAIL reset_hold ack=%b%b busy=%b exp 000", bus.ack0, bus.ack1, bus.busy); end
    end
    idle_inputs();
    rst = 1'b1;
    model_reset();
  endtask

  task automatic preload();
    int lat, wrc; logic [3:0] wa, wd; bit oa; logic [3:0] d;
    for (int i = 0; i < 16; i++) begin
      d = 4'($urandom_range(0, 15));
      run_single(1'(i % 2), 1'b1, 4'(i), d, lat, wrc, wa, wd, oa);
      model_apply(1'(i % 2), 1'b1, 4'(i), d);
      checks++; if (lat != 2 || wrc != 1) begin errors++; $display("FAIL preload_write[%0d] lat=%0d wr=%0d exp 2/1", i, lat, wrc); end
    end
  endtask

  task automatic test_single_write();
    int lat, wrc; logic [3:0] wa, wd; bit oa;
    run_single(1'b0, 1'b1, 4'h3, 4'b1000, lat, wrc, wa, wd, oa);
    model_apply(1'b0, 1'b1, 4'h3, 4'b1000);
    checks++; if (lat != 2) begin errors++; $display("FAIL write_latency got %0d exp 2", lat); end
    checks++; if (wrc != 1) begin errors++; $display("FAIL write_ram_wr_cycles got %0d exp 1", wrc); end
    checks++; if (wa !== 4'h3 || wd !== 4'h8) begin errors++; $display("FAIL write_ram_pins got addr=%h din=%h exp 3/8", wa, wd); end
    checks++; if (oa) begin errors++; $display("FAIL write_ack1 got 1 exp 0"); end
    checks++; if (bus.rdata0 !== exp_rd0) begin errors++; $display("FAIL write_rdata0 got %h exp %h", bus.rdata0, exp_rd0); end
  endtask

  task automatic test_read_back();
    int lat, wrc; logic [3:0] wa, wd; bit oa;
    run_single(1'b1, 1'b0, 4'h3, 4'h0, lat, wrc, wa, wd, oa);
    model_apply(1'b1, 1'b0, 4'h3, 4'h0);
    checks++; if (lat != 3) begin errors++; $display("FAIL read_latency got %0d exp 3", lat); end
    checks++; if (wrc != 0) begin errors++; $display("FAIL read_ram_wr got %0d cycles exp 0", wrc); end
    checks++; if (bus.rdata1 !== 4'b1000 || bus.rdata1 !== exp_rd1) begin errors++; $display("FAIL read_rdata1 got %h exp 8", bus.rdata1); end
    checks++; if (oa) begin errors++; $display("FAIL read_ack0 got 1 exp 0"); end
  endtask

  task automatic test_contention();
    bit order[$]; int ack0_cyc; bit first;
    quiet_reset();
    ack0_cyc = -1;
    first = model_winner(1'b1, 1'b1);
    @(negedge clk);
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 4'h5; bus.wdata0 = 4'hA;
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 4'h5; bus.wdata1 = 4'h0;
    for (int c = 1; c <= 30 && order.size() < 2; c++) begin
      @(negedge clk);
      if (bus.ack0 && bus.ack1) begin checks++; errors++; $display("FAIL contention_dual_ack got 11 exp one-hot"); end
      if (bus.ack0) begin order.push_back(1'b0); ack0_cyc = c; bus.req0 = 1'b0; model_apply(1'b0, 1'b1, 4'h5, 4'hA); end
      if (bus.ack1) begin order.push_back(1'b1); bus.req1 = 1'b0; model_apply(1'b1, 1'b0, 4'h5, 4'h0); end
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    checks++; if (order.size() != 2) begin errors++; $display("FAIL contention_acks got %0d exp 2", order.size()); end
    else begin
      checks++; if (order[0] !== first || first !== 1'b0) begin errors++; $display("FAIL contention_first got %0d exp 0", order[0]); end
      checks++; if (order[1] !== 1'b1) begin errors++; $display("FAIL contention_second got %0d exp 1", order[1]); end
    end
    checks++; if (ack0_cyc != 2) begin errors++; $display("FAIL contention_ack0_latency got %0d exp 2", ack0_cyc); end
    checks++; if (bus.rdata1 !== 4'hA || bus.rdata1 !== exp_rd1) begin errors++; $display("FAIL contention_rdata1 got %h exp a", bus.rdata1); end
    @(negedge clk);
  endtask

  task automatic test_fairness();
    int n; bit expw; logic [3:0] a0, a1;
    n = 0;
    a0 = 4'($urandom_range(0, 15));
    a1 = 4'($urandom_range(0, 15));
    @(negedge clk);
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = a0;
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = a1;
    for (int c = 0; c < 80 && n < 6; c++) begin
      @(negedge clk);
      if (!bus.req0) begin a0 = 4'($urandom_range(0, 15)); bus.addr0 = a0; bus.req0 = 1'b1; end
      if (!bus.req1) begin a1 = 4'($urandom_range(0, 15)); bus.addr1 = a1; bus.req1 = 1'b1; end
      if (bus.ack0 || bus.ack1) begin
        expw = model_winner(1'b1, 1'b1);
        checks++; if (bus.ack1 !== expw || bus.ack0 !== ~expw) begin errors++; $display("FAIL fairness_order[%0d] got ack=%b%b exp port %0d", n, bus.ack1, bus.ack0, expw); end
        model_apply(expw, 1'b0, expw ? a1 : a0, 4'h0);
        checks++; if ((expw ? bus.rdata1 : bus.rdata0) !== (expw ? exp_rd1 : exp_rd0))
          begin errors++; $display("FAIL fairness_rdata[%0d] got %h exp %h", n, expw ? bus.rdata1 : bus.rdata0, expw ? exp_rd1 : exp_rd0); end
        if (bus.ack0) bus.req0 = 1'b0;
        if (bus.ack1) bus.req1 = 1'b0;
        n++;
        if (n == 6) begin bus.req0 = 1'b0; bus.req1 = 1'b0; end
      end
    end
    checks++; if (n != 6) begin errors++; $display("FAIL fairness_count got %0d exp 6", n); end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset_mid_write();
    int lat, wrc; logic [3:0] wa, wd; bit oa; logic [3:0] pre; bit acked;
    pre = 4'($urandom_range(0, 14));
    run_single(1'b0, 1'b1, 4'h7, pre, lat, wrc, wa, wd, oa);
    model_apply(1'b0, 1'b1, 4'h7, pre);
    @(negedge clk);
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 4'h7; bus.wdata0 = 4'hF;
    @(posedge clk);
    #2;
    checks++; if (bus.ram_wr !== 1'b1) begin errors++; $display("FAIL midrst_grant_wr got %b exp 1", bus.ram_wr); end
    rst = 1'b0;
    #1;
    checks++; if (bus.ram_wr !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_drop got wr=%b busy=%b exp 0/0", bus.ram_wr, bus.busy); end
    bus.req0 = 1'b0;
    acked = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.ack0 || bus.ack1) acked = 1'b1;
    end
    rst = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.ack0 || bus.ack1) acked = 1'b1;
    end
    checks++; if (acked) begin errors++; $display("FAIL midrst_no_ack got 1 exp 0"); end
    run_single(1'b1, 1'b0, 4'h7, 4'h0, lat, wrc, wa, wd, oa);
    model_apply(1'b1, 1'b0, 4'h7, 4'h0);
    checks++; if (lat != 3 || bus.rdata1 !== exp_rd1 || bus.rdata1 === 4'hF)
      begin errors++; $display("FAIL midrst_readback got %h lat=%0d exp %h lat=3", bus.rdata1, lat, exp_rd1); end
  endtask

  task automatic test_random();
    int lat, wrc; logic [3:0] wa, wd; bit oa; bit p, we; logic [3:0] a, d, other_before;
    for (int i = 0; i < 24; i++) begin
      p  = 1'($urandom_range(0, 1));
      we = 1'($urandom_range(0, 1));
      a  = 4'($urandom_range(0, 15));
      d  = 4'($urandom_range(0, 15));
      other_before = p ? exp_rd0 : exp_rd1;
      run_single(p, we, a, d, lat, wrc, wa, wd, oa);
      model_apply(p, we, a, d);
      checks++; if (lat != (we ? 2 : 3) || wrc != (we ? 1 : 0) || oa)
        begin errors++; $display("FAIL random[%0d] lat=%0d wr=%0d oack=%b exp lat=%0d wr=%0d", i, lat, wrc, oa, we ? 2 : 3, we ? 1 : 0); end
      if (we) begin
        checks++; if (wa !== a || wd !== d) begin errors++; $display("FAIL random_pins[%0d] got %h/%h exp %h/%h", i, wa, wd, a, d); end
      end
      checks++; if (bus.rdata0 !== exp_rd0 || bus.rdata1 !== exp_rd1 || (p ? bus.rdata0 : bus.rdata1) !== other_before)
        begin errors++; $display("FAIL random_rdata[%0d] got %h/%h exp %h/%h", i, bus.rdata0, bus.rdata1, exp_rd0, exp_rd1); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    idle_inputs();
    model_reset();
    for (int i = 0; i < 16; i++) ref_mem[i] = 4'h0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    test_reset();
    preload();
    test_single_write();
    test_read_back();
    test_contention();
    test_fairness();
    test_reset_mid_write();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ram_share_ctrl.md
# ram_share_ctrl

Two-port requester arbiter and sequencer for the shared 16x4 single-port RAM (`ram`: clk, din, wr, addr, dout). Accepts read/write requests from two independent masters over a req/ack handshake. Arbitrates round-robin, drives the RAM control pins for exactly one access cycle, and returns read data with a one-cycle ack pulse. Sits between the RAM instance and its users, replacing direct tie-off of `wr`/`addr`/`din`.

## Interface
- `AW`, 4, RAM address width
- `DW`, 4, RAM data width
- `clk` input 1: single clock, all state updates on posedge
- `rst` input 1: asynchronous, active-low reset
- `req0` / `req1` input 1: request from port 0 / 1
- `we0` / `we1` input 1: 1 = write, 0 = read; held stable while req high
- `addr0` / `addr1` input AW: access address; held stable while req high
- `wdata0` / `wdata1` input DW: write data; held stable while req high
- `ack0` / `ack1` output 1: one-cycle completion pulse per port
- `rdata0` / `rdata1` output DW: read result for that port, valid with ack, held until that port's next read completes
- `busy` output 1: high in every state except IDLE
- `ram_wr` output 1: to RAM `wr`
- `ram_addr` output AW: to RAM `addr`
- `ram_din` output DW: to RAM `din`
- `ram_dout` input DW: from RAM `dout`; the RAM registers it at the posedge where addr is presented with wr=0

## Operation
- States: IDLE, GRANT, WAIT, RESP.
- IDLE, no req: stay.
- IDLE, any req: select a port, latch its we/addr/wdata into internal regs, record it as `sel`, go to GRANT.
- Arbitration: single req wins. Both high: port != `last` wins. `last` resets to 1, so port 0 wins first.
- GRANT (one cycle): `ram_addr` = latched addr. `ram_din` = latched wdata. `ram_wr` = latched we. Write → RESP; read → WAIT.
- WAIT (one cycle): `ram_dout` is valid. At the closing edge, load it into `rdata[sel]`, then go to RESP.
- RESP (one cycle): `ack[sel]` = 1. At the closing edge, set `last` ← `sel` and go to IDLE.
- `ram_wr` is 1 only in GRANT with latched we=1; 0 in all other states.
- `ram_addr` and `ram_din` hold the last latched values outside GRANT.
- Requester rule: drop req in the cycle after seeing ack. A req still high in the IDLE after RESP is a new request and re-arbitrates normally.
- A req arriving while busy is not sampled until IDLE. Its inputs must stay stable until its own ack.
- Write data is never forwarded to rdata. A write does not change rdata.
- Addresses are used as-is; there is no wrap or range logic (all 2^AW addresses are valid).
- The unselected port's inputs are ignored for the entire transaction.

## Timing
- Reset values (asynchronous, immediate on rst=0):
  - state = IDLE, `last` = 1
  - `ack0` = `ack1` = 0, `busy` = 0
  - `ram_wr` = 0, `ram_addr` = 0, `ram_din` = 0
  - `rdata0` = `rdata1` = 0
- Write latency, with req sampled high in IDLE at edge E0:
  - GRANT in cycle E0–E1; the RAM writes at E1
  - ack in cycle E1–E2
  - total 2 cycles from the sampling edge to the ack cycle
- Read latency: GRANT E0–E1, WAIT E1–E2, ack with valid rdata in E2–E3 (3 cycles).
- Throughput: back-to-back transactions need one IDLE cycle between RESP and the next GRANT, so a write takes 3 cycles per transaction and a read takes 4.
- ack is a Moore output of the registered state: glitch-free and exactly one cycle wide.
- Reset asserted mid-transaction:
  - outputs go to reset values without waiting for clk
  - a pending write in GRANT is cancelled, since `ram_wr` drops immediately
  - no ack is issued
  - the requester must re-request after reset releases
- Reset deassertion: the first evaluation happens at the first posedge with rst=1.

## Test plan
- Reset: hold rst=0 for 2 cycles with random req/addr. Required: all outputs at reset values, `busy`=0, no ack. Then release.
- Single write: port 0, we0=1, addr0=4'h3, wdata0=4'b1000.
  - `ram_wr`=1 for exactly one cycle with `ram_addr`=3 and `ram_din`=8
  - `ack0` pulses 2 cycles after the sampling edge
  - `ack1` stays 0, `rdata0` unchanged
- Read-back: port 1, we1=0, addr1=4'h3 after the above write. Required: `ram_wr` stays 0, and `ack1` pulses 3 cycles after the sampling edge with `rdata1`=4'b1000.
- Contention after reset:
  - stimulus: both req high in the same cycle; port 0 writes addr 5 data 4'hA, port 1 reads addr 5
  - port 0 is served first
  - port 1 is then served, and `rdata1`=4'hA
- Fairness: both ports hold req continuously, re-raising it after each ack, for 6 transactions. Required: ack alternates 0,1,0,1,0,1 and no port is starved.
- Reset mid-write: assert rst=0 during GRANT of a write to addr 7 with data 4'hF.
  - `ram_wr` falls immediately, and no ack is issued
  - a subsequent read of addr 7 does not return 4'hF (compare against the RAM pre-reset contents)
